// File: rtl/adc_receiver.sv
// adc_receiver: oversampled serial ADC receiver, deserialises 24-bit L/R samples into 48-bit FIFO words.
// Default framing is left-justified; define ADC_RX_I2S_EN to switch to Philips I2S framing.
module adc_receiver #(
   parameter int DATA_W      = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_clk36,
   input  logic                  i_rst36,
   input  logic                  i_bck,
   input  logic                  i_lrck,
   input  logic                  i_data,
   input  logic                  i_full,
   input  logic                  i_clr,
   output logic [2*DATA_W-1:0]   o_lraudio,
   output logic                  o_wrreq,
   output logic                  o_locked,
   output logic                  o_overrun,
   output logic [7:0]            o_err_cnt
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_LEFT   = 2'd1,
      ST_RIGHT  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
   logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   bck_dly_q, bck_dly_d;
   logic                   lrck_dly_q, lrck_dly_d;

   logic                   bck_rise_s, lrck_rise_s, lrck_fall_s;
   logic                   frame_start_s, boundary_s;

   logic                   ev_bck_q, ev_bck_d;
   logic                   ev_start_q, ev_start_d;
   logic                   ev_bound_q, ev_bound_d;
   logic                   ev_data_q, ev_data_d;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]      shift_q, shift_d;
   logic [DATA_W-1:0]      left_q, left_d;
   logic [2*DATA_W-1:0]    word_q, word_d;
   logic                   frame_done_q, frame_done_d;
   logic                   err_q, err_d;
   logic [CNT_W-1:0]       cnt_s;
   logic [DATA_W-1:0]      shift_s;
`ifdef ADC_RX_I2S_EN
   logic                   skip_q, skip_d;
   logic                   skip_s;
`endif

   logic                   wrreq_q, wrreq_d;
   logic [2*DATA_W-1:0]    lraudio_q, lraudio_d;
   logic                   locked_q, locked_d;
   logic                   overrun_q, overrun_d;
   logic [7:0]             err_cnt_q, err_cnt_d;

   // Synchroniser shift, edge-detect delay taps and registered edge events
   always_comb begin
      bck_sync_d  = {bck_sync_q[SYNC_STAGES-2:0], i_bck};
      lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], i_lrck};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], i_data};
      bck_dly_d   = bck_sync_q[SYNC_STAGES-1];
      lrck_dly_d  = lrck_sync_q[SYNC_STAGES-1];
      ev_bck_d    = bck_rise_s;
      ev_start_d  = frame_start_s;
      ev_bound_d  = boundary_s;
      ev_data_d   = data_sync_q[SYNC_STAGES-1];
   end

   assign bck_rise_s  =  bck_sync_q[SYNC_STAGES-1]  & ~bck_dly_q;
   assign lrck_rise_s =  lrck_sync_q[SYNC_STAGES-1] & ~lrck_dly_q;
   assign lrck_fall_s = ~lrck_sync_q[SYNC_STAGES-1] &  lrck_dly_q;

`ifdef ADC_RX_I2S_EN
   assign frame_start_s = lrck_fall_s;
   assign boundary_s    = lrck_rise_s;
`else
   assign frame_start_s = lrck_rise_s;
   assign boundary_s    = lrck_fall_s;
`endif

   // Frame state machine: channel edges are handled before the same-cycle BCK rise
   always_comb begin
      state_d      = state_q;
      cnt_s        = bit_cnt_q;
      shift_s      = shift_q;
      left_d       = left_q;
      word_d       = word_q;
      frame_done_d = 1'b0;
      err_d        = 1'b0;
`ifdef ADC_RX_I2S_EN
      skip_s       = skip_q;
`endif
      case (state_q)
         ST_SEARCH: begin
            if (ev_start_q) begin
               state_d = ST_LEFT;
               cnt_s   = '0;
               shift_s = '0;
`ifdef ADC_RX_I2S_EN
               skip_s  = 1'b1;
`endif
            end else begin
               state_d = ST_SEARCH;
            end
         end
         ST_LEFT: begin
            if (ev_bound_q) begin
               if (bit_cnt_q == CNT_FULL) begin
                  left_d  = shift_q;
                  state_d = ST_RIGHT;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_SEARCH;
               end
               cnt_s   = '0;
               shift_s = '0;
`ifdef ADC_RX_I2S_EN
               skip_s  = 1'b1;
`endif
            end else begin
               state_d = ST_LEFT;
            end
         end
         ST_RIGHT: begin
            if (ev_start_q) begin
               // a short right half still leaves us on a valid frame start
               if (bit_cnt_q == CNT_FULL) begin
                  frame_done_d = 1'b1;
                  word_d       = {left_q, shift_q};
               end else begin
                  err_d        = 1'b1;
               end
               state_d = ST_LEFT;
               cnt_s   = '0;
               shift_s = '0;
`ifdef ADC_RX_I2S_EN
               skip_s  = 1'b1;
`endif
            end else begin
               state_d = ST_RIGHT;
            end
         end
         default: begin
            state_d = ST_SEARCH;
            cnt_s   = '0;
            shift_s = '0;
         end
      endcase

      if (ev_bck_q && (state_d != ST_SEARCH)) begin
`ifdef ADC_RX_I2S_EN
         if (skip_s) begin
            skip_s = 1'b0;
         end else if (cnt_s != CNT_FULL) begin
            shift_s = {shift_s[DATA_W-2:0], ev_data_q};
            cnt_s   = cnt_s + CNT_ONE;
         end else begin
            cnt_s   = CNT_FULL;
         end
`else
         if (cnt_s != CNT_FULL) begin
            shift_s = {shift_s[DATA_W-2:0], ev_data_q};
            cnt_s   = cnt_s + CNT_ONE;
         end else begin
            cnt_s   = CNT_FULL;
         end
`endif
      end else begin
         cnt_s = cnt_s;
      end

      bit_cnt_d = cnt_s;
      shift_d   = shift_s;
`ifdef ADC_RX_I2S_EN
      skip_d    = skip_s;
`endif
   end

   // Output stage: FIFO write, overrun, lock and error counter
   always_comb begin
      wrreq_d   = 1'b0;
      lraudio_d = lraudio_q;
      if (frame_done_q && !i_full) begin
         wrreq_d   = 1'b1;
         lraudio_d = word_q;
      end else begin
         lraudio_d = lraudio_q;
      end

      if (frame_done_q && i_full) begin
         overrun_d = 1'b1;
      end else if (i_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      if (err_q) begin
         locked_d = 1'b0;
      end else if (frame_done_q && !i_full) begin
         locked_d = 1'b1;
      end else begin
         locked_d = locked_q;
      end

      if (err_q) begin
         if (i_clr) begin
            err_cnt_d = 8'd1;
         end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end else begin
            err_cnt_d = err_cnt_q;
         end
      end else if (i_clr) begin
         err_cnt_d = 8'd0;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge i_clk36) begin
      if (i_rst36) begin
         bck_sync_q   <= '0;
         lrck_sync_q  <= '0;
         data_sync_q  <= '0;
         bck_dly_q    <= 1'b0;
         lrck_dly_q   <= 1'b0;
         ev_bck_q     <= 1'b0;
         ev_start_q   <= 1'b0;
         ev_bound_q   <= 1'b0;
         ev_data_q    <= 1'b0;
         state_q      <= ST_SEARCH;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         left_q       <= '0;
         word_q       <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
`ifdef ADC_RX_I2S_EN
         skip_q       <= 1'b0;
`endif
         wrreq_q      <= 1'b0;
         lraudio_q    <= '0;
         locked_q     <= 1'b0;
         overrun_q    <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         bck_sync_q   <= bck_sync_d;
         lrck_sync_q  <= lrck_sync_d;
         data_sync_q  <= data_sync_d;
         bck_dly_q    <= bck_dly_d;
         lrck_dly_q   <= lrck_dly_d;
         ev_bck_q     <= ev_bck_d;
         ev_start_q   <= ev_start_d;
         ev_bound_q   <= ev_bound_d;
         ev_data_q    <= ev_data_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         left_q       <= left_d;
         word_q       <= word_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
`ifdef ADC_RX_I2S_EN
         skip_q       <= skip_d;
`endif
         wrreq_q      <= wrreq_d;
         lraudio_q    <= lraudio_d;
         locked_q     <= locked_d;
         overrun_q    <= overrun_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign o_lraudio = lraudio_q;
   assign o_wrreq   = wrreq_q;
   assign o_locked  = locked_q;
   assign o_overrun = overrun_q;
   assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_adc_receiver.sv
// tb_adc_receiver: table-driven frames plus hand sequences for error, overrun and reset corners.
// Builds in left-justified mode by default, or I2S mode when ADC_RX_I2S_EN is defined.
module tb_adc_receiver;

   localparam int DATA_W = 24;
   localparam int SYNC   = 2;
`ifdef ADC_RX_I2S_EN
   localparam logic LEFT_LVL = 1'b0;
   localparam int   SKIP     = 1;
`else
   localparam logic LEFT_LVL = 1'b1;
   localparam int   SKIP     = 0;
`endif

   logic        i_clk36 = 1'b0;
   logic        i_rst36, i_bck, i_lrck, i_data, i_full, i_clr;
   logic [47:0] o_lraudio;
   logic        o_wrreq, o_locked, o_overrun;
   logic [7:0]  o_err_cnt;

   adc_receiver #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
      .i_clk36   (i_clk36),
      .i_rst36   (i_rst36),
      .i_bck     (i_bck),
      .i_lrck    (i_lrck),
      .i_data    (i_data),
      .i_full    (i_full),
      .i_clr     (i_clr),
      .o_lraudio (o_lraudio),
      .o_wrreq   (o_wrreq),
      .o_locked  (o_locked),
      .o_overrun (o_overrun),
      .o_err_cnt (o_err_cnt)
   );

   always #5 i_clk36 = ~i_clk36;

   int          n_checks = 0;
   int          n_err    = 0;
   int          edge_cnt = 0;
   int          fs_edge  = 0;
   int          wr_count = 0;
   logic [47:0] last_word = '0;
   logic        prev_wr = 1'b0;

   typedef struct packed {
      logic [23:0] left;
      logic [23:0] right;
      logic [7:0]  nl;
      logic [7:0]  nr;
      logic [7:0]  exp_words;
      logic [47:0] exp_word;
      logic        exp_locked;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge i_clk36) edge_cnt <= edge_cnt + 1;

   // Word monitor: pulse width and frame-start-to-write latency
   initial begin
      forever begin
         @(negedge i_clk36);
         if (o_wrreq) begin
            wr_count++;
            last_word = o_lraudio;
            check("wrreq_single_cycle", 64'(prev_wr), 64'd0);
            check("wrreq_latency", 64'(edge_cnt - fs_edge), 64'(SYNC + 2));
         end
         prev_wr = o_wrreq;
      end
   end

   // One BCK period = 16 clocks; LRCK and DATA change with BCK falling
   task automatic half(input logic lvl, input logic [23:0] val, input int first, input int last);
      int j;
      for (int i = first; i < last; i++) begin
         @(negedge i_clk36);
         i_bck = 1'b0;
         if (i == 0) begin
            i_lrck = lvl;
            if (lvl == LEFT_LVL) fs_edge = edge_cnt + 1;
         end
         j = i - SKIP;
         if (j < 0) i_data = ~val[23];
         else if (j < 24) i_data = val[23-j];
         else i_data = 1'b1;
         repeat (8) @(negedge i_clk36);
         i_bck = 1'b1;
         repeat (7) @(negedge i_clk36);
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int nl, input int nr);
      half(LEFT_LVL, l, 0, nl + SKIP);
      half(~LEFT_LVL, r, 0, nr + SKIP);
   endtask

   task automatic check_outputs(input string tag, input logic [47:0] word, input logic wr,
                                input logic lk, input logic ov, input logic [7:0] ec);
      check({tag, "_lraudio"}, 64'(o_lraudio), 64'(word));
      check({tag, "_wrreq"},   64'(o_wrreq),   64'(wr));
      check({tag, "_locked"},  64'(o_locked),  64'(lk));
      check({tag, "_overrun"}, 64'(o_overrun), 64'(ov));
      check({tag, "_err_cnt"}, 64'(o_err_cnt), 64'(ec));
   endtask

   initial begin
      int w0;
      i_rst36 = 1'b1; i_bck = 1'b0; i_lrck = ~LEFT_LVL; i_data = 1'b0;
      i_full = 1'b0; i_clr = 1'b0;
      repeat (5) @(negedge i_clk36);
      check_outputs("reset", 48'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      i_rst36 = 1'b0;
      repeat (20) @(negedge i_clk36);

      vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 8'd24, 8'd24, 8'd0, 48'h0,            1'b0};
      vecs[1] = '{24'hA5A5A5, 24'h5A5A5A, 8'd24, 8'd24, 8'd1, 48'hA5A5A55A5A5A, 1'b1};
      vecs[2] = '{24'hA5A5A5, 24'h5A5A5A, 8'd24, 8'd24, 8'd1, 48'hA5A5A55A5A5A, 1'b1};
      vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 8'd24, 8'd24, 8'd1, 48'hA5A5A55A5A5A, 1'b1};
      vecs[4] = '{24'h800001, 24'h7FFFFF, 8'd32, 8'd32, 8'd1, 48'hA5A5A55A5A5A, 1'b1};
      vecs[5] = '{24'h123456, 24'hFEDCBA, 8'd24, 8'd24, 8'd1, 48'h8000017FFFFF, 1'b1};
      vecs[6] = '{24'h0F0F0F, 24'hF0F0F0, 8'd24, 8'd24, 8'd1, 48'h123456FEDCBA, 1'b1};

      for (int v = 0; v < 7; v++) begin
         w0 = wr_count;
         send_frame(vecs[v].left, vecs[v].right, int'(vecs[v].nl), int'(vecs[v].nr));
         check($sformatf("vec%0d_words", v), 64'(wr_count - w0), 64'(vecs[v].exp_words));
         if (vecs[v].exp_words != 8'd0)
            check($sformatf("vec%0d_word", v), 64'(last_word), 64'(vecs[v].exp_word));
         check($sformatf("vec%0d_locked", v), 64'(o_locked), 64'(vecs[v].exp_locked));
      end

      // short left half: previous word still issued, then error and loss of lock
      w0 = wr_count;
      send_frame(24'hA5A5A5, 24'h5A5A5A, 20, 24);
      check("short_words", 64'(wr_count - w0), 64'd1);
      check("short_word", 64'(last_word), 64'h0F0F0FF0F0F0);
      check("short_err_cnt", 64'(o_err_cnt), 64'd1);
      check("short_locked", 64'(o_locked), 64'd0);
      w0 = wr_count;
      send_frame(24'h111111, 24'h222222, 24, 24);
      check("resync_words", 64'(wr_count - w0), 64'd0);
      w0 = wr_count;
      send_frame(24'h333333, 24'h444444, 24, 24);
      check("recover_words", 64'(wr_count - w0), 64'd1);
      check("recover_word", 64'(last_word), 64'h111111222222);
      check("recover_locked", 64'(o_locked), 64'd1);
      check("recover_err_cnt", 64'(o_err_cnt), 64'd1);

      // FIFO full across one frame completion
      i_full = 1'b1;
      w0 = wr_count;
      send_frame(24'h555555, 24'h666666, 24, 24);
      check("full_words", 64'(wr_count - w0), 64'd0);
      check("full_overrun", 64'(o_overrun), 64'd1);
      check("full_locked", 64'(o_locked), 64'd1);
      i_full = 1'b0;
      w0 = wr_count;
      send_frame(24'h777777, 24'h888888, 24, 24);
      check("release_words", 64'(wr_count - w0), 64'd1);
      check("release_word", 64'(last_word), 64'h555555666666);
      check("overrun_sticky", 64'(o_overrun), 64'd1);
      @(negedge i_clr or negedge i_clk36);
      i_clr = 1'b1;
      @(negedge i_clk36);
      i_clr = 1'b0;
      @(negedge i_clk36);
      check("clr_overrun", 64'(o_overrun), 64'd0);
      check("clr_err_cnt", 64'(o_err_cnt), 64'd0);

      // reset in the middle of the right half
      w0 = wr_count;
      half(LEFT_LVL, 24'h999999, 0, 24 + SKIP);
      half(~LEFT_LVL, 24'hAAAAAA, 0, 12 + SKIP);
      check("prereset_words", 64'(wr_count - w0), 64'd1);
      check("prereset_word", 64'(last_word), 64'h777777888888);
      @(negedge i_clk36);
      i_rst36 = 1'b1;
      repeat (3) @(negedge i_clk36);
      check_outputs("midreset", 48'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      i_rst36 = 1'b0;
      half(~LEFT_LVL, 24'hAAAAAA, 12 + SKIP, 24 + SKIP);
      w0 = wr_count;
      send_frame(24'hBBBBBB, 24'hCCCCCC, 24, 24);
      check("postreset_words", 64'(wr_count - w0), 64'd0);
      check("postreset_locked", 64'(o_locked), 64'd0);
      w0 = wr_count;
      send_frame(24'hDDDDDD, 24'hEEEEEE, 24, 24);
      check("postreset2_words", 64'(wr_count - w0), 64'd1);
      check("postreset2_word", 64'(last_word), 64'hBBBBBBCCCCCC);
      check("postreset2_locked", 64'(o_locked), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
